uart_tx_ctrl: RTL and testbench

- UART transmit controller. Sequences one serial frame per accepted byte: start bit, DATA_BITS data bits LSB first, one stop bit.
- Owns two modulo counters: a baud divider that rolls over every CLKS_PER_BIT cycles and a bit index that rolls over at DATA_BITS.
- Sits between the byte-producing logic (valid/ready handshake) and the TX pin.

---
 rtl/uart_tx_ctrl.sv | 132 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl
//   UART transmit controller. It accepts one word through a valid/ready
//   handshake and sends it as one serial frame: a start bit, then DATA_BITS
//   data bits LSB first, then one stop bit. Every bit lasts CLKS_PER_BIT
//   cycles.
//
// Ports
//   clk       in   system clock; all state changes on posedge
//   reset_n   in   asynchronous active-low reset
//   tx_valid  in   producer has a word on tx_data
//   tx_data   in   word to send (DATA_BITS wide); sampled only on acceptance
//   tx_ready  out  controller can accept a word (IDLE only)
//   tx_out    out  registered serial line, idles high
//   busy      out  frame in progress (START/DATA/STOP)
//   done      out  one-cycle pulse on the first IDLE cycle after a stop bit
//
// state | meaning
// ------+-------------------------------------------------------
// IDLE  | line high, waiting for tx_valid
// START | driving the start bit (0)
// DATA  | shifting data bits out, LSB first
// STOP  | driving the stop bit (1); done follows on its last edge

module uart_tx_ctrl #(
  parameter int CLKS_PER_BIT = 8,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_out,
  output logic                 busy,
  output logic                 done
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_nxt;
  logic [BW-1:0]        baud_cnt, baud_cnt_nxt;
  logic [IW-1:0]        bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_reg_nxt;
  logic                 tx_out_nxt;
  logic                 done_nxt;
  logic                 bit_end;

  assign bit_end  = (baud_cnt == BAUD_LAST);
  assign tx_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      tx_out    <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      baud_cnt  <= baud_cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_reg_nxt;
      tx_out    <= tx_out_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    baud_cnt_nxt  = baud_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    done_nxt      = 1'b0;
    tx_out_nxt    = 1'b1;

    // The baud divider runs in every non-idle state and wraps on bit_end,
    // so each bit of the frame gets exactly CLKS_PER_BIT cycles.
    if (state != IDLE) begin
      baud_cnt_nxt = bit_end ? '0 : baud_cnt + BW'(1);
    end

    case (state)
      IDLE: begin
        if (tx_valid) begin
          shift_reg_nxt = tx_data;
          baud_cnt_nxt  = '0;
          state_nxt     = START;
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_nxt = '0;
          state_nxt   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_reg_nxt = {1'b0, shift_reg[DATA_BITS-1:1]};
          if (bit_idx == IDX_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_idx_nxt = bit_idx + IW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // tx_out is registered from the next-state values so the line level
    // changes on the same edge as the state, with no path from tx_valid.
    case (state_nxt)
      START:   tx_out_nxt = 1'b0;
      DATA:    tx_out_nxt = shift_reg_nxt[0];
      default: tx_out_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       valid_a, ready_a, out_a, busy_a, done_a;
  logic [7:0] data_a;
  logic       valid_b, ready_b, out_b, busy_b, done_b;
  logic [4:0] data_b;

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_a), .tx_data(data_a),
    .tx_ready(ready_a), .tx_out(out_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_ctrl #(.CLKS_PER_BIT(2), .DATA_BITS(5)) dut_b (
    .clk(clk), .reset_n(reset_n), .tx_valid(valid_b), .tx_data(data_b),
    .tx_ready(ready_b), .tx_out(out_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input int sel);
    chk("idle_tx_out", sel ? out_b   : out_a,   1);
    chk("idle_ready",  sel ? ready_b : ready_a, 1);
    chk("idle_busy",   sel ? busy_b  : busy_a,  0);
    chk("idle_done",   sel ? done_b  : done_a,  0);
  endtask

  // Expected line levels for one frame, one entry per bit period.
  task automatic push_frame(input logic [8:0] d, input int nbits);
    exp_q.push_back(1'b0);
    for (int i = 0; i < nbits; i++) exp_q.push_back(d[i]);
    exp_q.push_back(1'b1);
  endtask

  // Called at the negedge right after the acceptance edge. Checks every
  // cycle of the frame, then the done/ready cycle that follows it.
  // poke>0 drives a stray tx_valid/tx_data on instance A at that cycle.
  task automatic expect_frame(input int sel, input int cpb, input int nbits, input int poke);
    int   cyc;
    logic e;
    cyc = 1;
    for (int b = 0; b < nbits + 2; b++) begin
      chk("queue_nonempty", (exp_q.size() > 0), 1);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
      for (int c = 0; c < cpb; c++) begin
        if (poke > 0 && cyc == poke) begin
          data_a  = 8'hFF;
          valid_a = 1'b1;
        end else if (poke > 0 && cyc == poke + 1) begin
          valid_a = 1'b0;
        end
        chk("frame_tx_out", sel ? out_b   : out_a,   e);
        chk("frame_busy",   sel ? busy_b  : busy_a,  1);
        chk("frame_ready",  sel ? ready_b : ready_a, 0);
        chk("frame_done",   sel ? done_b  : done_a,  0);
        @(negedge clk);
        cyc++;
      end
    end
    chk("end_done",   sel ? done_b  : done_a,  1);
    chk("end_ready",  sel ? ready_b : ready_a, 1);
    chk("end_busy",   sel ? busy_b  : busy_a,  0);
    chk("end_tx_out", sel ? out_b   : out_a,   1);
  endtask

  initial begin
    reset_n = 1'b0;
    valid_a = 1'b1;
    data_a  = 8'hA5;
    valid_b = 1'b1;
    data_b  = 5'h1F;

    // reset held with tx_valid high
    repeat (3) begin
      @(negedge clk);
      check_idle(0);
      check_idle(1);
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    check_idle(0);
    check_idle(1);

    // single frame 8'hA5
    data_a  = 8'hA5;
    valid_a = 1'b1;
    push_frame({1'b0, data_a}, 8);
    @(negedge clk);
    valid_a = 1'b0;
    expect_frame(0, 4, 8, 0);
    @(negedge clk);
    check_idle(0);

    // back-to-back 8'h00 then 8'hFF with tx_valid held high
    data_a  = 8'h00;
    valid_a = 1'b1;
    push_frame({1'b0, data_a}, 8);
    @(negedge clk);
    data_a = 8'hFF;
    push_frame({1'b0, data_a}, 8);
    expect_frame(0, 4, 8, 0);
    @(negedge clk);
    valid_a = 1'b0;
    expect_frame(0, 4, 8, 0);
    @(negedge clk);
    check_idle(0);

    // busy masking: stray data/valid at cycle 10
    data_a  = 8'h3C;
    valid_a = 1'b1;
    push_frame({1'b0, data_a}, 8);
    @(negedge clk);
    valid_a = 1'b0;
    expect_frame(0, 4, 8, 10);
    repeat (3) begin
      @(negedge clk);
      check_idle(0);
    end

    // reset during data bit 3 (cycles 17..20 after acceptance)
    data_a  = 8'h35;
    valid_a = 1'b1;
    @(negedge clk);
    valid_a = 1'b0;
    repeat (17) @(negedge clk);
    chk("mid_bit3_tx_out", out_a, 0);
    chk("mid_bit3_busy", busy_a, 1);
    reset_n = 1'b0;
    #1;
    chk("async_tx_out", out_a, 1);
    chk("async_busy", busy_a, 0);
    chk("async_ready", ready_a, 1);
    repeat (2) begin
      @(negedge clk);
      check_idle(0);
    end
    reset_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_idle(0);
    end
    data_a  = 8'h81;
    valid_a = 1'b1;
    push_frame({1'b0, data_a}, 8);
    @(negedge clk);
    valid_a = 1'b0;
    expect_frame(0, 4, 8, 0);
    @(negedge clk);
    check_idle(0);

    // parameter corner: CLKS_PER_BIT=2, DATA_BITS=5
    data_b  = 5'b10110;
    valid_b = 1'b1;
    push_frame({4'b0, data_b}, 5);
    @(negedge clk);
    valid_b = 1'b0;
    expect_frame(1, 2, 5, 0);
    @(negedge clk);
    check_idle(1);

    chk("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
